// File: rtl/sys_bus_bridge_pkg.sv
// sys_bus_bridge_pkg: shared address map, FSM/select encodings and window decode
package sys_bus_bridge_pkg;
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] BR_BASE  = 32'h0000_7F20;
  localparam int WIN_WORDS = 3;
  localparam int BR_WORDS  = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_TC0  = 2'd1;
  localparam logic [1:0] SEL_TC1  = 2'd2;
  localparam logic [1:0] SEL_BR   = 2'd3;
  localparam int PEND_TC0 = 0;
  localparam int PEND_TC1 = 1;
  localparam int PEND_EXT = 2;
  // unsigned wrap makes addresses below the base fail the compare too
  function automatic logic in_win(input logic [29:0] a, input logic [31:0] base, input int words);
    logic [29:0] off;
    off = a - base[31:2];
    return off < 30'(words);
  endfunction
  function automatic logic [1:0] decode(input logic [29:0] a);
    return in_win(a, TC0_BASE, WIN_WORDS) ? SEL_TC0 :
           in_win(a, TC1_BASE, WIN_WORDS) ? SEL_TC1 :
           in_win(a, BR_BASE, BR_WORDS)   ? SEL_BR  : SEL_NONE;
  endfunction
endpackage

// File: rtl/sys_bus_bridge_irq.sv
// sys_bus_bridge_irq: ext_irq synchronizer, rising-edge detect, sticky W1C pending, mask and hw_int
module sys_bus_bridge_irq
  import sys_bus_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_irq0,
  input  logic       i_irq1,
  input  logic       i_ext_irq,
  input  logic       i_clr_we,
  input  logic       i_mask_we,
  input  logic [2:0] i_wdata,
  output logic [2:0] o_pending,
  output logic [2:0] o_mask,
  output logic [2:0] o_hw_int
);
  logic [1:0] r_sync;
  logic [2:0] r_prev, w_lvl, w_rise, w_pend_nxt, w_mask_nxt;
  assign w_lvl[PEND_TC0] = i_irq0;
  assign w_lvl[PEND_TC1] = i_irq1;
  assign w_lvl[PEND_EXT] = r_sync[1];
  assign w_rise = w_lvl & ~r_prev;
  // OR-ing the edge after the clear lets a simultaneous set win
  assign w_pend_nxt = (o_pending & ~(i_clr_we ? i_wdata : 3'b0)) | w_rise;
  assign w_mask_nxt = i_mask_we ? i_wdata : o_mask;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_prev    <= '0;
      o_pending <= '0;
      o_mask    <= '0;
      o_hw_int  <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_ext_irq};
      r_prev    <= w_lvl;
      o_pending <= w_pend_nxt;
      o_mask    <= w_mask_nxt;
      o_hw_int  <= w_pend_nxt & w_mask_nxt;
    end
endmodule

// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: CPU-side initiator of the peripheral register bus; decodes to TC0/TC1/bridge regs
module sys_bus_bridge
  import sys_bus_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [29:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev_we0,
  output logic        dev_we1,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic        irq0,
  input  logic        irq1,
  input  logic        ext_irq,
  output logic [2:0]  hw_int
);
  logic [1:0]  r_state, r_sel;
  logic        r_we;
  logic        w_acc, w_br_we;
  logic [2:0]  w_pending, w_mask;
  logic [31:0] w_rsrc;
  assign w_acc   = r_state == ST_ACCESS;
  assign dev_we0 = w_acc && r_we && r_sel == SEL_TC0;
  assign dev_we1 = w_acc && r_we && r_sel == SEL_TC1;
  assign w_br_we = w_acc && r_we && r_sel == SEL_BR;
  // BR_BASE is word-aligned to an even word, so addr[0] picks pending vs mask
  always_comb
    w_rsrc = r_sel == SEL_TC0 ? dev_rdata0 :
             r_sel == SEL_TC1 ? dev_rdata1 :
             r_sel == SEL_BR  ? {29'b0, dev_addr[0] ? w_mask : w_pending} : 32'b0;
  sys_bus_bridge_irq u_irq (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_irq0    (irq0),
    .i_irq1    (irq1),
    .i_ext_irq (ext_irq),
    .i_clr_we  (w_br_we && !dev_addr[0]),
    .i_mask_we (w_br_we && dev_addr[0]),
    .i_wdata   (dev_wdata[2:0]),
    .o_pending (w_pending),
    .o_mask    (w_mask),
    .o_hw_int  (hw_int)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sel     <= SEL_NONE;
      r_we      <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
    end else begin
      r_state <= r_state == ST_IDLE   ? (cpu_req ? ST_ACCESS : ST_IDLE) :
                 r_state == ST_ACCESS ? ST_RESP : ST_IDLE;
      cpu_ack <= w_acc;
      cpu_err <= w_acc && r_sel == SEL_NONE;
      if (r_state == ST_IDLE && cpu_req) begin
        dev_addr  <= cpu_addr;
        dev_wdata <= cpu_wdata;
        r_we      <= cpu_we;
        r_sel     <= decode(cpu_addr);
      end
      if (w_acc && (!r_we || r_sel == SEL_NONE))
        cpu_rdata <= w_rsrc;
    end
endmodule

// File: tb/tb_sys_bus_bridge.sv
// tb_sys_bus_bridge: scoreboard bench for the bus bridge; expectations queued at request, checked at ack
module tb_sys_bus_bridge;
  logic        clk = 0, reset = 0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic [29:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_we0, dev_we1;
  logic [31:0] dev_rdata0 = '0, dev_rdata1 = '0;
  logic        irq0 = 0, irq1 = 0, ext_irq = 0;
  logic [2:0]  hw_int;
  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          w0;
    int          w1;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  logic [31:0] model_rd = '0;

  sys_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we0(dev_we0), .dev_we1(dev_we1),
    .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1), .irq0(irq0), .irq1(irq1),
    .ext_irq(ext_irq), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic xfer(input logic we, input logic [31:0] baddr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int ew0, input int ew1,
                      input logic early);
    exp_t e;
    int w0, w1, lat;
    logic [29:0] sa;
    logic [31:0] sw;
    logic got;
    e.we = we; e.addr = baddr[31:2]; e.wdata = wd; e.err = exp_err; e.w0 = ew0; e.w1 = ew1;
    e.rdata = (we && !exp_err) ? model_rd : exp_rd;
    model_rd = e.rdata;
    sb.push_back(e);
    @(negedge clk);
    n_vec++;
    if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL ack_pulse: ack=%b want 0 before request", cpu_ack); end
    cpu_req = 1; cpu_we = we; cpu_addr = baddr[31:2]; cpu_wdata = wd;
    w0 = 0; w1 = 0; lat = 0; got = 0; sa = '0; sw = '0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (early) cpu_req = 0;
      if (dev_we0 || dev_we1) begin sa = dev_addr; sw = dev_wdata; end
      w0 += int'(dev_we0);
      w1 += int'(dev_we1);
      if (cpu_ack === 1'b1) begin got = 1; lat = n; cpu_req = 0; end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_timeout addr=%h: no ack within 8 cycles", baddr);
    end else begin
      e = sb.pop_front();
      n_vec += 5;
      if (lat != 2) begin n_err++; $display("FAIL latency addr=%h: %0d want 2", baddr, lat); end
      if (cpu_err !== e.err) begin n_err++; $display("FAIL err addr=%h: %b want %b", baddr, cpu_err, e.err); end
      if (cpu_rdata !== e.rdata) begin n_err++; $display("FAIL rdata addr=%h: %h want %h", baddr, cpu_rdata, e.rdata); end
      if (w0 != e.w0) begin n_err++; $display("FAIL we0_count addr=%h: %0d want %0d", baddr, w0, e.w0); end
      if (w1 != e.w1) begin n_err++; $display("FAIL we1_count addr=%h: %0d want %0d", baddr, w1, e.w1); end
      if (e.w0 + e.w1 > 0) begin
        n_vec += 2;
        if (sa !== e.addr) begin n_err++; $display("FAIL dev_addr: %h want %h", sa, e.addr); end
        if (sw !== e.wdata) begin n_err++; $display("FAIL dev_wdata: %h want %h", sw, e.wdata); end
      end
    end
  endtask

  task automatic chk_hw(input string nm, input logic [2:0] want);
    n_vec++;
    if (hw_int !== want) begin n_err++; $display("FAIL %s: hw_int=%b want %b", nm, hw_int, want); end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cpu_ack, cpu_err, dev_we0, dev_we1} !== 4'b0 || cpu_rdata !== '0 || dev_addr !== '0 ||
        dev_wdata !== '0 || hw_int !== '0) begin
      n_err++;
      $display("FAIL reset_state: ack=%b err=%b we0=%b we1=%b rd=%h da=%h dw=%h hw=%b want all 0",
               cpu_ack, cpu_err, dev_we0, dev_we1, cpu_rdata, dev_addr, dev_wdata, hw_int);
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_tc_access();
    xfer(1, 32'h7F00, 32'h9, 0, 0, 1, 0, 0);
    dev_rdata1 = 32'h1234;
    xfer(0, 32'h7F18, 0, 32'h1234, 0, 0, 0, 0);
    dev_rdata0 = 32'hDEAD_BEEF;
    xfer(0, 32'h7F08, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    xfer(1, 32'h7F14, 32'hA5, 0, 0, 0, 1, 0);
  endtask

  task automatic test_unmapped();
    xfer(0, 32'h7F0C, 0, 0, 1, 0, 0, 0);
    xfer(1, 32'h8000, 32'h5, 0, 1, 0, 0, 0);
    xfer(1, 32'h7F28, 32'h7, 0, 1, 0, 0, 0);
    xfer(0, 32'h7EFC, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_irq_w1c();
    xfer(1, 32'h7F24, 32'h3, 0, 0, 0, 0, 0);
    irq1 = 1;
    @(negedge clk);
    chk_hw("irq1_edge", 3'b010);
    xfer(0, 32'h7F20, 0, 32'h2, 0, 0, 0, 0);
    xfer(1, 32'h7F20, 32'h2, 0, 0, 0, 0, 0);
    xfer(0, 32'h7F20, 0, 32'h0, 0, 0, 0, 0);
    chk_hw("w1c_held_high", 3'b000);
  endtask

  task automatic test_ext_mask();
    ext_irq = 1;
    repeat (3) @(negedge clk);
    chk_hw("ext_masked", 3'b000);
    xfer(0, 32'h7F20, 0, 32'h4, 0, 0, 0, 0);
    xfer(1, 32'h7F24, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    chk_hw("ext_unmasked", 3'b100);
    xfer(0, 32'h7F24, 0, 32'h4, 0, 0, 0, 0);
  endtask

  task automatic test_set_wins();
    fork
      xfer(1, 32'h7F20, 32'h1, 0, 0, 0, 0, 0);
      begin @(negedge clk); @(negedge clk); irq0 = 1; end
    join
    xfer(0, 32'h7F20, 0, 32'h5, 0, 0, 0, 0);
    chk_hw("set_wins", 3'b100);
    xfer(1, 32'h7F20, 32'h7, 0, 0, 0, 0, 0);
    xfer(0, 32'h7F20, 0, 32'h0, 0, 0, 0, 0);
    chk_hw("clear_all", 3'b000);
  endtask

  task automatic test_back_to_back();
    dev_rdata0 = 32'h0000_0055;
    xfer(1, 32'h7F14, 32'hCAFE, 0, 0, 0, 1, 1);
    xfer(0, 32'h7F04, 0, 32'h55, 0, 0, 0, 0);
    xfer(0, 32'h7F10, 0, 32'h1234, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 30'h1FC0; cpu_wdata = 32'h77;
    @(negedge clk);
    n_vec++;
    if (dev_we0 !== 1'b1) begin n_err++; $display("FAIL mid_strobe: we0=%b want 1", dev_we0); end
    #1 reset = 0; cpu_req = 0;
    irq0 = 0; irq1 = 0; ext_irq = 0;
    #1;
    n_vec++;
    if ({cpu_ack, cpu_err, dev_we0, dev_we1} !== 4'b0 || cpu_rdata !== '0 || dev_addr !== '0 ||
        dev_wdata !== '0 || hw_int !== '0) begin
      n_err++;
      $display("FAIL abort_state: ack=%b err=%b we0=%b rd=%h da=%h dw=%h hw=%b want all 0",
               cpu_ack, cpu_err, dev_we0, cpu_rdata, dev_addr, dev_wdata, hw_int);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack: ack=%b want 0", cpu_ack); end
    end
    reset = 1;
    model_rd = 0;
    repeat (3) @(negedge clk);
    xfer(0, 32'h7F20, 0, 32'h0, 0, 0, 0, 0);
    xfer(0, 32'h7F24, 0, 32'h0, 0, 0, 0, 0);
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left: %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_tc_access();
    test_unmapped();
    test_irq_w1c();
    test_ext_mask();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sys_bus_bridge.md
Name: sys_bus_bridge

Overview:
- CPU-side initiator end of the peripheral register bus; the timer/counter devices are the responders on that bus.
- Accepts one CPU load/store at a time and decodes it to TC0, TC1 or the bridge's own registers.
- Drives the word-addressed device bus: shared addr/wdata, per-device write strobe, per-device read data.
- Collects device IRQ levels plus one external interrupt into a masked, sticky pending register that drives the CPU hardware-interrupt line.

Parameters:
- TC0_BASE, 32'h0000_7F00, byte base of TC0 window (3 words: ctrl/preset/count)
- TC1_BASE, 32'h0000_7F10, byte base of TC1 window (3 words)
- BR_BASE, 32'h0000_7F20, byte base of bridge registers (2 words: pending, mask)
- WIN_WORDS, 3, valid words per TC window; word offsets 3 and above are unmapped

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held high until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req high
- cpu_addr  in  30  word address [31:2]
- cpu_wdata  in  32  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  unmapped access flag, valid with cpu_ack
- cpu_rdata  out  32  read data, valid with cpu_ack
- dev_addr  out  30  word address to devices [31:2]
- dev_wdata  out  32  write data to devices
- dev_we0  out  1  TC0 write strobe
- dev_we1  out  1  TC1 write strobe
- dev_rdata0  in  32  TC0 read data, combinational from dev_addr
- dev_rdata1  in  32  TC1 read data
- irq0  in  1  TC0 IRQ level
- irq1  in  1  TC1 IRQ level
- ext_irq  in  1  asynchronous external interrupt level
- hw_int  out  3  pending & mask, to CPU/CP0

Behaviour:
- Reset (reset=0, async): state=IDLE, cpu_ack=0, cpu_err=0, cpu_rdata=0, dev_we0/1=0, dev_addr=0, dev_wdata=0, pending=0, mask=0, sync flops=0, hw_int=0.
- FSM states IDLE, ACCESS, RESP.
- IDLE: when cpu_req=1, register cpu_addr, cpu_we, cpu_wdata, and the decode result (TC0 / TC1 / BR / NONE); go to ACCESS.
- ACCESS (1 cycle): dev_addr and dev_wdata hold the latched values.
  - Write: dev_weN=1 for the selected TC only; bridge-register writes take effect at the end of this cycle.
  - Read: sample the selected read source into cpu_rdata at the end of this cycle.
  - Go to RESP.
- RESP (1 cycle): cpu_ack=1; cpu_err=1 only for NONE; go to IDLE. cpu_rdata holds until the next read completes.
- Latency: req sampled at edge t; strobe during cycle t+1; ack during cycle t+2. Back-to-back requests need one IDLE cycle, so minimum spacing is 3 cycles.
- Decode: hit when the word offset from base is less than WIN_WORDS for TC, or less than 2 for BR.
- NONE access: no strobe asserted, cpu_rdata=0, cpu_err=1. Reads of TC or BR words have no side effects.
- dev_weN is a single-cycle pulse; it is never asserted outside ACCESS.
- IRQ path:
  - ext_irq passes through a 2-flop synchronizer; irq0/irq1 are synchronous and used directly.
  - Rising-edge detect on each source (previous-level flop) sets pending[i].
  - pending bits: [0]=TC0, [1]=TC1, [2]=ext.
  - Writing BR+0 clears the pending bits where wdata bit is 1 (W1C).
  - If a set edge and a W1C clear hit the same bit in the same cycle, set wins.
  - Writing BR+4 stores mask[2:0]; upper bits read as 0.
  - hw_int = pending & mask, registered output.
  - A source held high does not re-set pending after a clear; only a new rising edge does.
- Reset mid-transaction: aborts the access with no ack; the CPU must reissue.
- cpu_req dropping before ack: the transaction completes anyway and the ack is still pulsed.

Decomposition:
- Shared package: base-address constants, state encoding (IDLE/ACCESS/RESP), pending bit indices, decode-select encoding.
- One natural sub-module: irq_collector (synchronizer, edge detect, pending/mask, hw_int).
- Decode and FSM stay in the top level.

Test Plan:
- Write 32'h9 to 0x7F00 -> dev_we0 high exactly 1 cycle, dev_addr=0x7F00>>2, dev_wdata=9; ack 2 cycles after req; err=0; dev_we1 stays 0.
- Read 0x7F18 with dev_rdata1=32'h1234 -> cpu_rdata=32'h1234 with ack, err=0.
- Read 0x7F0C (TC0 offset 3) and write 0x8000 -> ack with err=1, rdata=0, no strobe.
- Write mask=3'b011; pulse irq1 0->1 -> pending=3'b010, hw_int=3'b010; W1C write 3'b010 to 0x7F20 with irq1 still high -> pending=0, hw_int=0, no re-set.
- Raise ext_irq with mask[2]=0 -> pending[2]=1 after 3 cycles, hw_int[2]=0; set mask=3'b100 -> hw_int[2]=1. Drive a W1C of bit 0 in the same cycle as an irq0 rising edge -> pending[0]=1.
- Assert reset during ACCESS of a TC0 write -> dev_we0 drops immediately, no ack, and all outputs return to reset values.
